// File: rtl/cam_capture_pkg.sv
// cam_capture_pkg: state encoding, alpha, colour-bar table and RGB565 expansion shared by the DVP capture path
package cam_capture_pkg;
  localparam logic [1:0] ST_WAIT_VSYNC = 2'd0;
  localparam logic [1:0] ST_VBLANK     = 2'd1;
  localparam logic [1:0] ST_ACTIVE     = 2'd2;
  localparam logic [7:0] ALPHA = 8'hFF;
  localparam logic [31:0] COLOR_BARS [8] = '{
    32'hFFFFFFFF, 32'hFFFFFF00, 32'hFF00FFFF, 32'hFF00FF00,
    32'hFFFF00FF, 32'hFFFF0000, 32'hFF0000FF, 32'hFF000000
  };
  function automatic logic [31:0] rgb565_to_argb(input logic [15:0] p);
    return {ALPHA, p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
  endfunction
endpackage

// File: rtl/cam_test_pattern_gen.sv
// cam_test_pattern_gen: 8 vertical colour bars, each H_ACTIVE/8 pixels wide, selected by pixel index
// Ports: pix_cnt (in, pixel index within the line), color (out, ARGB8888 bar colour)
// Built only when TEST_PATTERN_EN is defined.
`ifdef TEST_PATTERN_EN
module cam_test_pattern_gen
  import cam_capture_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int PW = $clog2(H_ACTIVE + 1)
) (
  input  logic [PW-1:0] pix_cnt,
  output logic [31:0]   color
);
  localparam logic [PW-1:0] BAR_W = PW'(H_ACTIVE / 8);
  logic [PW-1:0] idx;
  assign idx = pix_cnt / BAR_W;
  assign color = (idx > PW'(7)) ? COLOR_BARS[7] : COLOR_BARS[idx[2:0]];
endmodule
`endif

// File: rtl/cam_dvp_capture.sv
// cam_dvp_capture: DVP RGB565 byte-stream capture with ARGB8888 expansion and frame geometry checking
// Ports: pclk/reset (sync, active-high); cam_data/cam_vsync/cam_href (DVP inputs);
//        tp_enable (colour-bar select, used with TEST_PATTERN_EN); pixel/pixel_valid (ARGB out);
//        sof (start-of-frame pulse); frame_count (frames started, wraps); frame_error (sticky)
// Optional feature macro: TEST_PATTERN_EN
module cam_dvp_capture
  import cam_capture_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 960,
  parameter int FCNT_W   = 16
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic [7:0]        cam_data,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic              tp_enable,
  output logic [31:0]       pixel,
  output logic              pixel_valid,
  output logic              sof,
  output logic [FCNT_W-1:0] frame_count,
  output logic              frame_error
);
  localparam int PW = $clog2(H_ACTIVE + 1);
  localparam int LW = $clog2(V_ACTIVE + 1);
  logic [7:0] r_data_q, hi_q, hi_d;
  logic r_vsync_q, r_href_q, vsync_prev_q, href_prev_q;
  logic phase_q, phase_d;
  logic [1:0] state_q, state_d;
  logic [PW-1:0] pix_cnt_q, pix_cnt_d;
  logic [LW-1:0] line_cnt_q, line_cnt_d, line_inc;
  logic [31:0] pixel_q, pixel_d, cam_pixel, out_pixel;
  logic pixel_valid_q, pixel_valid_d, sof_q, sof_d, frame_error_q, frame_error_d;
  logic [FCNT_W-1:0] frame_count_q, frame_count_d;
  logic vs_rise, vs_fall, href_fall, assemble, in_window, line_bad, frame_start;
  assign vs_rise     = r_vsync_q & ~vsync_prev_q;
  assign vs_fall     = ~r_vsync_q & vsync_prev_q;
  assign href_fall   = ~r_href_q & href_prev_q;
  assign frame_start = (state_q == ST_VBLANK) & vs_fall;
  // second byte of a pair while a frame is open; href during vsync never captures
  assign assemble  = (state_q == ST_ACTIVE) & r_href_q & ~r_vsync_q & phase_q;
  assign in_window = (pix_cnt_q < PW'(H_ACTIVE)) && (line_cnt_q < LW'(V_ACTIVE));
  assign line_inc  = (line_cnt_q == LW'(V_ACTIVE)) ? line_cnt_q : line_cnt_q + 1'b1;
  // phase is still 1 at the falling edge when the line carried an odd byte count
  assign line_bad  = (pix_cnt_q != PW'(H_ACTIVE)) || phase_q;
  assign cam_pixel = rgb565_to_argb({hi_q, r_data_q});
`ifdef TEST_PATTERN_EN
  logic tp_sel_q;
  logic [31:0] bar_color;
  cam_test_pattern_gen #(.H_ACTIVE(H_ACTIVE)) u_tp (.pix_cnt(pix_cnt_q), .color(bar_color));
  // frame-wide selection so a frame is never a mix of camera and bars
  always_ff @(posedge pclk) tp_sel_q <= reset ? 1'b0 : (frame_start ? tp_enable : tp_sel_q);
  assign out_pixel = tp_sel_q ? bar_color : cam_pixel;
`else
  logic tp_unused;
  assign tp_unused = tp_enable;
  assign out_pixel = cam_pixel;
`endif
  always_comb begin
    phase_d = r_href_q & ~phase_q;
    hi_d = (r_href_q & ~phase_q) ? r_data_q : hi_q;
    state_d = state_q;
    pix_cnt_d = (assemble && pix_cnt_q != PW'(H_ACTIVE)) ? pix_cnt_q + 1'b1 : pix_cnt_q;
    line_cnt_d = line_cnt_q;
    frame_count_d = frame_count_q;
    frame_error_d = frame_error_q;
    sof_d = 1'b0;
    pixel_valid_d = assemble & in_window;
    pixel_d = pixel_valid_d ? out_pixel : pixel_q;
    case (state_q)
      ST_WAIT_VSYNC: state_d = vs_rise ? ST_VBLANK : ST_WAIT_VSYNC;
      ST_VBLANK: if (vs_fall) begin
        state_d = ST_ACTIVE;
        sof_d = 1'b1;
        frame_count_d = frame_count_q + 1'b1;
        line_cnt_d = '0;
        pix_cnt_d = '0;
      end
      ST_ACTIVE: begin
        if (href_fall) begin
          line_cnt_d = line_inc;
          pix_cnt_d = '0;
          frame_error_d = frame_error_q | line_bad;
        end
        // a line closing in the same cycle is counted before the frame check
        if (vs_rise) begin
          state_d = ST_VBLANK;
          frame_error_d = frame_error_d | ((href_fall ? line_inc : line_cnt_q) != LW'(V_ACTIVE));
        end
      end
      default: state_d = ST_WAIT_VSYNC;
    endcase
  end
  always_ff @(posedge pclk) begin
    if (reset) begin
      r_data_q <= '0;
      r_vsync_q <= 1'b0;
      r_href_q <= 1'b0;
      vsync_prev_q <= 1'b0;
      href_prev_q <= 1'b0;
      phase_q <= 1'b0;
      hi_q <= '0;
      state_q <= ST_WAIT_VSYNC;
      pix_cnt_q <= '0;
      line_cnt_q <= '0;
      frame_count_q <= '0;
      frame_error_q <= 1'b0;
      sof_q <= 1'b0;
      pixel_valid_q <= 1'b0;
      pixel_q <= '0;
    end else begin
      r_data_q <= cam_data;
      r_vsync_q <= cam_vsync;
      r_href_q <= cam_href;
      vsync_prev_q <= r_vsync_q;
      href_prev_q <= r_href_q;
      phase_q <= phase_d;
      hi_q <= hi_d;
      state_q <= state_d;
      pix_cnt_q <= pix_cnt_d;
      line_cnt_q <= line_cnt_d;
      frame_count_q <= frame_count_d;
      frame_error_q <= frame_error_d;
      sof_q <= sof_d;
      pixel_valid_q <= pixel_valid_d;
      pixel_q <= pixel_d;
    end
  end
  assign pixel = pixel_q;
  assign pixel_valid = pixel_valid_q;
  assign sof = sof_q;
  assign frame_count = frame_count_q;
  assign frame_error = frame_error_q;
endmodule

// File: tb/tb_cam_dvp_capture.sv
// tb_cam_dvp_capture: randomized DVP stimulus checked against a frame/line level reference model
module tb_cam_dvp_capture;
  localparam int H = 16, V = 4;
  logic pclk = 1'b0, reset = 1'b1;
  logic [7:0] cam_data = '0;
  logic cam_vsync = 1'b0, cam_href = 1'b0, tp_enable = 1'b0;
  logic [31:0] pixel;
  logic pixel_valid, sof, frame_error;
  logic [15:0] frame_count;
  cam_dvp_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .FCNT_W(16)) dut (
    .pclk(pclk), .reset(reset), .cam_data(cam_data), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .tp_enable(tp_enable), .pixel(pixel), .pixel_valid(pixel_valid), .sof(sof),
    .frame_count(frame_count), .frame_error(frame_error)
  );
  always #5 pclk = ~pclk;
  int checks = 0, fails = 0;
  logic [31:0] exp_q [$];
  logic [31:0] cap [$];
  int n_valid = 0, n_sof = 0;
  logic prev_valid = 1'b0;
  bit seen_vs = 0, in_frame = 0, m_err = 0, tp_frame = 0;
  int m_lines = 0, m_frames = 0, m_sofs = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] expand(input logic [15:0] p);
    int r, g, b;
    r = int'(p[15:11]);
    g = int'(p[10:5]);
    b = int'(p[4:0]);
    return {8'hFF, 8'(r * 8 + r / 4), 8'(g * 4 + g / 16), 8'(b * 8 + b / 4)};
  endfunction

  function automatic logic [31:0] bar(input int k);
    return {8'hFF, (k & 2) != 0 ? 8'h00 : 8'hFF, (k & 4) != 0 ? 8'h00 : 8'hFF, (k & 1) != 0 ? 8'h00 : 8'hFF};
  endfunction

  always @(negedge pclk) begin
    if (pixel_valid) begin
      n_valid++;
      cap.push_back(pixel);
      check("valid_spacing", prev_valid, 0);
      check("sof_with_valid", sof, 0);
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL pixel_unexpected: got %08h, no pixel expected", pixel);
      end else check("pixel", pixel, exp_q.pop_front());
    end
    if (sof) n_sof++;
    prev_valid = pixel_valid;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic reset_model();
    seen_vs = 0; in_frame = 0; m_err = 0; m_frames = 0; m_lines = 0; tp_frame = 0;
  endtask

  task automatic rise_model();
    if (in_frame && m_lines != V) m_err = 1;
    in_frame = 0;
    seen_vs = 1;
  endtask

  task automatic vsync_rise(input int n);
    cam_vsync = 1'b1;
    rise_model();
    repeat (n) tick();
  endtask

  task automatic vsync_fall();
    bit start;
    start = seen_vs && !in_frame;
    cam_vsync = 1'b0;
    if (start) begin
      in_frame = 1; m_frames++; m_sofs++; m_lines = 0; tp_frame = tp_enable;
    end
    tick(); check("sof_early", sof, 0);
    tick(); check("sof_at_k2", sof, start);
    tick(); check("sof_width", sof, 0);
  endtask

  task automatic send_line(input int nbytes, input int gap, input bit fixed, input bit vs_end);
    logic [7:0] hb, b;
    int pc;
    bit first;
    pc = 0;
    hb = '0;
    first = in_frame && m_lines < V;
    for (int j = 0; j < nbytes; j++) begin
      b = fixed ? ((j % 2 != 0) ? 8'h1F : 8'hF8) : 8'($urandom);
      cam_href = 1'b1;
      cam_data = b;
      if (j % 2 == 0) hb = b;
      else begin
        if (in_frame && pc < H && m_lines < V) exp_q.push_back(tp_frame ? bar(pc / (H / 8)) : expand({hb, b}));
        pc++;
      end
      tick();
      if (j == 1) check("latency_early", pixel_valid, 0);
      if (j == 2) check("latency_k2", pixel_valid, first);
    end
    cam_href = 1'b0;
    cam_data = 8'($urandom);
    if (in_frame) begin
      if (nbytes % 2 != 0 || nbytes / 2 < H) m_err = 1;
      if (m_lines < V) m_lines++;
    end
    if (vs_end) begin
      cam_vsync = 1'b1;
      rise_model();
    end
    repeat (gap) tick();
  endtask

  task automatic frame(input int nlines, input bit fixed, input bit vs_end);
    vsync_fall();
    for (int l = 0; l < nlines; l++)
      send_line(32, (vs_end && l == nlines - 1) ? 4 : int'($urandom_range(1, 4)), fixed, vs_end && l == nlines - 1);
    if (!vs_end) vsync_rise(4);
  endtask

  task automatic checkpoint(input string tag);
    repeat (4) tick();
    check({tag, "_frame_count"}, frame_count, m_frames);
    check({tag, "_frame_error"}, frame_error, m_err);
    check({tag, "_sof_count"}, n_sof, m_sofs);
    check({tag, "_pending"}, exp_q.size(), 0);
  endtask

  task automatic reset_mid_line();
    logic [7:0] hb, b;
    hb = '0;
    for (int j = 0; j < 15; j++) begin
      b = 8'($urandom);
      cam_href = 1'b1;
      cam_data = b;
      if (j == 14) reset = 1'b1;
      else if (j % 2 == 0) hb = b;
      else exp_q.push_back(expand({hb, b}));
      tick();
    end
    check("valid_after_reset", pixel_valid, 0);
    check("pending_at_reset", exp_q.size(), 1);
    check("reset_frame_error", frame_error, 0);
    check("reset_frame_count", frame_count, 0);
    check("reset_pixel", pixel, 0);
    exp_q.delete();
    reset = 1'b0;
    cam_href = 1'b0;
    reset_model();
    tick();
  endtask

  initial begin
    int n0, s0, sz;
    repeat (3) tick();
    check("init_pixel", pixel, 0);
    check("init_valid", pixel_valid, 0);
    check("init_sof", sof, 0);
    check("init_frame_count", frame_count, 0);
    check("init_frame_error", frame_error, 0);
    reset = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) send_line(32, 3, 0, 0);
    vsync_rise(4);
    checkpoint("presync");
    check("presync_valid_count", n_valid, 0);
    n0 = n_valid;
    frame(4, 1, 0);
    frame(4, 1, 1);
    checkpoint("nominal");
    check("nominal_pixels", n_valid - n0, 128);
    check("nominal_last_pixel", cap[cap.size() - 1], 32'hFFFF00FF);
    check("nominal_frame_count", frame_count, 2);
    check("nominal_sofs", n_sof, 2);
    check("nominal_error", frame_error, 0);
    for (int f = 0; f < 4; f++) frame(4, 0, 1'($urandom_range(0, 1)));
    checkpoint("random");
    vsync_fall();
    n0 = n_valid;
    send_line(35, 3, 0, 0);
    repeat (2) tick();
    check("long_line_pixels", n_valid - n0, 16);
    check("long_line_error", frame_error, 1);
    for (int l = 0; l < 3; l++) send_line(32, 2, 0, 0);
    vsync_rise(4);
    checkpoint("long_line");
    vsync_fall();
    reset_mid_line();
    n0 = n_valid;
    s0 = n_sof;
    for (int i = 0; i < 2; i++) send_line(32, 3, 0, 0);
    repeat (3) tick();
    check("post_reset_no_pixels", n_valid - n0, 0);
    check("post_reset_no_sof", n_sof - s0, 0);
    vsync_rise(4);
    frame(4, 0, 0);
    checkpoint("after_reset");
    check("after_reset_frame_count", frame_count, 1);
    frame(3, 0, 0);
    checkpoint("short_frame");
    check("short_frame_error", frame_error, 1);
    s0 = n_sof;
    frame(4, 0, 0);
    check("sof_after_short", n_sof - s0, 1);
    checkpoint("post_short");
`ifdef TEST_PATTERN_EN
    tp_enable = 1'b1;
    vsync_fall();
    send_line(32, 2, 0, 0);
    sz = cap.size();
    check("tp_px0", cap[sz - 16], 32'hFFFFFFFF);
    check("tp_px1", cap[sz - 15], 32'hFFFFFFFF);
    check("tp_px14", cap[sz - 2], 32'hFF000000);
    check("tp_px15", cap[sz - 1], 32'hFF000000);
    tp_enable = 1'b0;
    for (int l = 0; l < 3; l++) send_line(32, 2, 0, 0);
    vsync_rise(4);
    vsync_fall();
    send_line(32, 2, 0, 0);
    tp_enable = 1'b1;
    for (int l = 0; l < 3; l++) send_line(32, 2, 0, 0);
    tp_enable = 1'b0;
    vsync_rise(4);
    checkpoint("test_pattern");
`else
    sz = cap.size();
    check("capture_nonempty", sz > 0, 1);
`endif
    checkpoint("final");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
